qsim_axi_sweeper: RTL and testbench

On-chip AXI4-Lite master that drives the quantum-simulator register block through a sweep of target basis states and streams back one amplitude result per target. It sits between a local control source (PS GPIO or a test sequencer) and the simulator's AXI-Lite slave port, which is clocked from the same `clk`. It replaces host software polling.

---
 rtl/qsim_axi_sweeper_pkg.sv | 30 +++
 rtl/qsim_axi_sweeper_if.sv | 38 +++
 rtl/qsim_axi_sweeper_xfer.sv | 116 +++++++++++
 rtl/qsim_axi_sweeper.sv | 178 +++++++++++++++++
 tb/tb_qsim_axi_sweeper.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qsim_axi_sweeper_pkg.sv
// Shared definitions for the quantum-simulator sweeper: register map, CONTROL/STATUS
// field positions, sweep FSM states and AXI response codes.
package qsim_axi_pkg;

  localparam logic [7:0] REG_SN      = 8'h00;
  localparam logic [7:0] REG_STATUS  = 8'h04;
  localparam logic [7:0] REG_TARGET  = 8'h08;
  localparam logic [7:0] REG_INITAL  = 8'h0C;
  localparam logic [7:0] REG_CONTROL = 8'h10;

  localparam int unsigned CTRL_GO_BIT    = 0;
  localparam int unsigned CTRL_REARM_BIT = 2;
  localparam logic [31:0] CTRL_GO_WORD    = 32'h1 << CTRL_GO_BIT;
  localparam logic [31:0] CTRL_REARM_WORD = 32'h1 << CTRL_REARM_BIT;
  localparam logic [31:0] CTRL_CLR_WORD   = 32'h0;

  localparam int unsigned ST_AMP_LSB = 20;
  localparam int unsigned ST_AMP_MSB = 31;
  localparam int unsigned ST_ENG_LSB = 0;
  localparam int unsigned ST_ENG_MSB = 1;
  localparam logic [1:0]  ENG_RESULT = 2'd3;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SN, S_WR_TGT, S_WR_INIT, S_WR_GO, S_POLL,
    S_GAP, S_EMIT, S_WR_ARM, S_WR_CLR, S_DONE, S_ERR
  } sweep_state_e;

endpackage

// File: rtl/qsim_axi_sweeper_if.sv
// AXI4-Lite bus between the sweeper (master) and the simulator register block (slave).
interface qsim_axi_sweeper_if;
  logic [7:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/qsim_axi_sweeper_xfer.sv
// Single-transaction AXI4-Lite engine: one read or write per req, ack pulses when the
// response has been taken, with rdata and a response-error flag.
module axil_master_xfer
  import qsim_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        resp_err,
  qsim_axi_sweeper_if.master axi
);

  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic [7:0]  awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic        ack_q, ack_d, resp_err_q, resp_err_d;

  always_comb begin
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    ack_d      = 1'b0;

    if (req) begin
      if (we) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        awaddr_d  = addr;
        wdata_d   = wdata;
      end else begin
        arvalid_d = 1'b1;
        araddr_d  = addr;
      end
    end

    // AW and W retire independently; BREADY follows once neither is outstanding.
    if (awvalid_q && axi.awready) awvalid_d = 1'b0;
    if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
    if ((awvalid_q || wvalid_q) && !awvalid_d && !wvalid_d) bready_d = 1'b1;

    if (bready_q && axi.bvalid) begin
      bready_d   = 1'b0;
      ack_d      = 1'b1;
      resp_err_d = (axi.bresp != AXI_OKAY);
    end

    if (arvalid_q && axi.arready) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end

    if (rready_q && axi.rvalid) begin
      rready_d   = 1'b0;
      ack_d      = 1'b1;
      rdata_d    = axi.rdata;
      resp_err_d = (axi.rresp != AXI_OKAY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign axi.awaddr  = awaddr_q;
  assign axi.awprot  = '0;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = '1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = araddr_q;
  assign axi.arprot  = '0;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign resp_err    = resp_err_q;

endmodule

// File: rtl/qsim_axi_sweeper.sv
// Sweeps the simulator over a range of target basis states via AXI-Lite and streams
// one (target, amplitude) result per target.
module qsim_axi_sweeper
  import qsim_axi_pkg::*;
#(
  parameter int unsigned POLL_GAP   = 4,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] init_state,
  input  logic [15:0] tgt_first,
  input  logic [15:0] tgt_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_target,
  output logic [11:0] res_amp,
  qsim_axi_sweeper_if.master m
);

  localparam int unsigned PCW = $clog2(POLL_LIMIT + 1);
  localparam int unsigned GCW = $clog2(POLL_GAP + 1);

  sweep_state_e state_q, state_d;
  logic [15:0]  cur_q, cur_d, last_q, last_d, init_q, init_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d, poll_inc;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
  logic         busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic         res_valid_q, res_valid_d;
  logic [15:0]  res_target_q, res_target_d;
  logic [11:0]  res_amp_q, res_amp_d;

  logic         x_req, x_we, x_ack, x_resp_err;
  logic [7:0]   x_addr;
  logic [31:0]  x_wdata, x_rdata;

  axil_master_xfer u_xfer (
    .clk      (clk),
    .rst      (rst),
    .req      (x_req),
    .we       (x_we),
    .addr     (x_addr),
    .wdata    (x_wdata),
    .ack      (x_ack),
    .rdata    (x_rdata),
    .resp_err (x_resp_err),
    .axi      (m)
  );

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_d       = last_q;
    init_d       = init_q;
    poll_cnt_d   = poll_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    err_d        = err_q;
    res_valid_d  = res_valid_q;
    res_target_d = res_target_q;
    res_amp_d    = res_amp_q;
    poll_inc     = poll_cnt_q + PCW'(1);

    unique case (state_q)
      S_IDLE: if (start) begin
        err_d   = 1'b0;
        cur_d   = tgt_first;
        last_d  = tgt_last;
        init_d  = init_state;
        state_d = (tgt_last < tgt_first) ? S_ERR : S_RD_SN;
      end
      S_RD_SN: if (x_ack) state_d = (x_resp_err || x_rdata == '0) ? S_ERR : S_WR_TGT;
      S_WR_TGT: if (x_ack) state_d = x_resp_err ? S_ERR : S_WR_INIT;
      S_WR_INIT: if (x_ack) state_d = x_resp_err ? S_ERR : S_WR_GO;
      S_WR_GO: if (x_ack) begin
        poll_cnt_d = '0;
        state_d    = x_resp_err ? S_ERR : S_POLL;
      end
      S_POLL: if (x_ack) begin
        poll_cnt_d = poll_inc;
        if (x_resp_err) begin
          state_d = S_ERR;
        end else if (x_rdata[ST_ENG_MSB:ST_ENG_LSB] == ENG_RESULT) begin
          state_d      = S_EMIT;
          res_valid_d  = 1'b1;
          res_target_d = cur_q;
          res_amp_d    = x_rdata[ST_AMP_MSB:ST_AMP_LSB];
        end else if (poll_inc == PCW'(POLL_LIMIT)) begin
          state_d = S_ERR;
        end else begin
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GCW'(POLL_GAP - 1)) state_d = S_POLL;
        else gap_cnt_d = gap_cnt_q + GCW'(1);
      end
      S_EMIT: if (res_ready) begin
        res_valid_d = 1'b0;
        state_d     = S_WR_ARM;
      end
      S_WR_ARM: if (x_ack) state_d = x_resp_err ? S_ERR : S_WR_CLR;
      S_WR_CLR: if (x_ack) begin
        // Compare before increment so a sweep ending at 0xFFFF terminates.
        if (x_resp_err) state_d = S_ERR;
        else if (cur_q == last_q) state_d = S_DONE;
        else begin
          cur_d   = cur_q + 16'd1;
          state_d = S_WR_TGT;
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERR) err_d = 1'b1;
    busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERR});
    done_d = (state_d == S_DONE);

    // Every bus state is entered from a different state, so entry issues its request.
    x_req   = (state_d != state_q);
    x_we    = 1'b1;
    x_addr  = '0;
    x_wdata = '0;
    unique case (state_d)
      S_RD_SN:   begin x_we = 1'b0; x_addr = REG_SN; end
      S_WR_TGT:  begin x_addr = REG_TARGET;  x_wdata = {16'h0, cur_d}; end
      S_WR_INIT: begin x_addr = REG_INITAL;  x_wdata = {16'h0, init_d}; end
      S_WR_GO:   begin x_addr = REG_CONTROL; x_wdata = CTRL_GO_WORD; end
      S_POLL:    begin x_we = 1'b0; x_addr = REG_STATUS; end
      S_WR_ARM:  begin x_addr = REG_CONTROL; x_wdata = CTRL_REARM_WORD; end
      S_WR_CLR:  begin x_addr = REG_CONTROL; x_wdata = CTRL_CLR_WORD; end
      default:   x_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      init_q       <= '0;
      poll_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      res_target_q <= '0;
      res_amp_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      init_q       <= init_d;
      poll_cnt_q   <= poll_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      res_valid_q  <= res_valid_d;
      res_target_q <= res_target_d;
      res_amp_q    <= res_amp_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign res_valid  = res_valid_q;
  assign res_target = res_target_q;
  assign res_amp    = res_amp_q;

endmodule

// File: tb/tb_qsim_axi_sweeper.sv
// Bench for qsim_axi_sweeper: behavioural register-block slave plus a transaction/result
// model built from the sweep rules, checked every cycle from one process.
module tb_qsim_axi_sweeper;
  import qsim_axi_pkg::*;

  localparam int unsigned GAP   = 4;
  localparam int unsigned LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] init_state = '0, tgt_first = '0, tgt_last = '0;
  logic        busy, done, err, res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_target;
  logic [11:0] res_amp;

  qsim_axi_sweeper_if bus ();

  qsim_axi_sweeper #(.POLL_GAP(GAP), .POLL_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .init_state (init_state),
    .tgt_first  (tgt_first),
    .tgt_last   (tgt_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_target (res_target),
    .res_amp    (res_amp),
    .m          (bus)
  );

  always #5 clk = ~clk;

  // Slave behaviour knobs, written only by the stimulus process.
  logic        wait_en = 1'b0, hold_aw = 1'b0, bresp_on_go = 1'b0, rdy_toggle = 1'b0;
  logic [31:0] sn_val = 32'h5151_0001;
  int          hit_poll = 2;

  function automatic logic [11:0] amp_of(input logic [15:0] t);
    return 12'(32'd0 - (32'(t) + 32'd2));
  endfunction

  function automatic logic [31:0] status_word(input logic [15:0] t, input int n);
    if (hit_poll != 0 && n == hit_poll) return {amp_of(t), 10'b0, t[6:0], 1'b1, 2'b11};
    return {12'h000, 10'b0, t[6:0], 1'b0, 2'b01};
  endfunction

  function automatic logic rnd();
    return wait_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // ---------------- slave register block ----------------
  logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
  logic [7:0]  aw_a, ar_a;
  logic [31:0] w_d;
  logic [15:0] cur_tgt = '0;
  int          poll_n = 0;
  logic        obs_we   [0:1023];
  logic [7:0]  obs_addr [0:1023];
  logic [31:0] obs_data [0:1023];
  int          obs_wr = 0;

  always @(posedge clk) begin
    if (rst) begin
      bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; poll_n <= 0;
    end else begin
      bus.awready <= !hold_aw && !aw_got && rnd();
      bus.wready  <= !w_got && rnd();
      bus.arready <= !ar_got && rnd();
      if (bus.awvalid && bus.awready) begin aw_got <= 1'b1; aw_a <= bus.awaddr; end
      if (bus.wvalid && bus.wready)   begin w_got <= 1'b1;  w_d  <= bus.wdata;  end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (aw_got && w_got && !bus.bvalid && rnd()) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= (bresp_on_go && aw_a == 8'h10 && w_d == 32'h1) ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
        if (aw_a == 8'h08) begin cur_tgt <= w_d[15:0]; poll_n <= 0; end
        obs_we[obs_wr] <= 1'b1; obs_addr[obs_wr] <= aw_a; obs_data[obs_wr] <= w_d;
        obs_wr <= obs_wr + 1;
      end
      if (bus.arvalid && bus.arready) begin ar_got <= 1'b1; ar_a <= bus.araddr; end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (ar_got && !bus.rvalid && rnd()) begin
        bus.rvalid <= 1'b1;
        bus.rresp  <= 2'b00;
        bus.rdata  <= (ar_a == 8'h00) ? sn_val :
                      (ar_a == 8'h04) ? status_word(cur_tgt, poll_n + 1) : 32'h0;
        if (ar_a == 8'h04) poll_n <= poll_n + 1;
        ar_got <= 1'b0;
        obs_we[obs_wr] <= 1'b0; obs_addr[obs_wr] <= ar_a; obs_data[obs_wr] <= '0;
        obs_wr <= obs_wr + 1;
      end
    end
  end

  // ---------------- model and checker ----------------
  typedef struct packed { logic we; logic [7:0] addr; logic [31:0] data; } txn_t;
  typedef struct packed { logic [15:0] t; logic [11:0] a; } res_t;
  txn_t exp_q[$];
  res_t res_q[$];
  int   n_cmp = 0, n_bad = 0, obs_rd = 0;
  int   done_cnt, res_cnt, status_reads;
  logic prev_rv = 1'b0, prev_rdy = 1'b0;
  logic [15:0] prev_t, last_t;
  logic [11:0] prev_a, last_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic void push_w(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, data: d});
  endfunction
  function automatic void push_r(input logic [7:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
  endfunction

  // Expected bus traffic and results for a clean sweep: SN read, then per target the
  // three setup writes, hit_poll status reads, and the re-arm/clear writes.
  function automatic void model_sweep(input int first, input int last, input logic [15:0] init);
    push_r(8'h00);
    for (int t = first; t <= last; t++) begin
      push_w(8'h08, 32'(t));
      push_w(8'h0C, {16'h0, init});
      push_w(8'h10, 32'h1);
      for (int p = 0; p < hit_poll; p++) push_r(8'h04);
      push_w(8'h10, 32'h4);
      push_w(8'h10, 32'h0);
      res_q.push_back('{t: 16'(t), a: amp_of(16'(t))});
    end
  endfunction

  task automatic tick();
    res_t r;
    txn_t e;
    @(negedge clk);
    if (rdy_toggle) res_ready = 1'($urandom_range(0, 1));
    if (bus.awvalid || bus.wvalid) begin
      chk("awprot", {29'b0, bus.awprot}, 32'h0);
      chk("wstrb", {28'b0, bus.wstrb}, 32'hF);
    end
    if (bus.arvalid) chk("arprot", {29'b0, bus.arprot}, 32'h0);
    if (prev_rv && !prev_rdy && !rst) begin
      chk("res_hold_valid", {31'b0, res_valid}, 32'h1);
      chk("res_hold_target", {16'b0, res_target}, {16'b0, prev_t});
      chk("res_hold_amp", {20'b0, res_amp}, {20'b0, prev_a});
    end
    if (res_valid && res_ready) begin
      res_cnt++;
      last_t = res_target;
      last_a = res_amp;
      if (res_q.size() == 0) chk("unexpected_result", {16'b0, res_target}, 32'hFFFF_FFFF);
      else begin
        r = res_q.pop_front();
        chk("res_target", {16'b0, res_target}, {16'b0, r.t});
        chk("res_amp", {20'b0, res_amp}, {20'b0, r.a});
      end
    end
    prev_rv = res_valid; prev_rdy = res_ready; prev_t = res_target; prev_a = res_amp;
    while (obs_rd < obs_wr) begin
      if (!obs_we[obs_rd] && obs_addr[obs_rd] == 8'h04) status_reads++;
      if (exp_q.size() == 0) chk("unexpected_axi", {obs_we[obs_rd], 23'b0, obs_addr[obs_rd]}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("axi_dir", {31'b0, obs_we[obs_rd]}, {31'b0, e.we});
        chk("axi_addr", {24'b0, obs_addr[obs_rd]}, {24'b0, e.addr});
        if (e.we) chk("axi_wdata", obs_data[obs_rd], e.data);
      end
      obs_rd++;
    end
    if (done) done_cnt++;
  endtask

  task automatic run(input logic [15:0] first, input logic [15:0] last, input logic [15:0] init,
                     input bit expect_err, input int n_results);
    done_cnt = 0; res_cnt = 0; status_reads = 0;
    init_state = init; tgt_first = first; tgt_last = last;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (last >= first) begin
      chk("start_busy", {31'b0, busy}, 32'h1);
      chk("start_arvalid", {31'b0, bus.arvalid}, 32'h1);
      chk("start_araddr", {24'b0, bus.araddr}, 32'h0);
    end else begin
      chk("badrange_err", {31'b0, err}, 32'h1);
      chk("badrange_busy", {31'b0, busy}, 32'h0);
    end
    for (int c = 0; c < 4000 && !(done || err); c++) tick();
    if (!(done || err)) chk("completion_timeout", 32'h0, 32'h1);
    for (int c = 0; c < 30; c++) tick();
    chk("exp_traffic_left", 32'(exp_q.size()), 32'h0);
    chk("exp_results_left", 32'(res_q.size()), 32'h0);
    chk("result_count", 32'(res_cnt), 32'(n_results));
    chk("done_pulses", 32'(done_cnt), expect_err ? 32'h0 : 32'h1);
    chk("err_flag", {31'b0, err}, {31'b0, expect_err});
    chk("idle_busy", {31'b0, busy}, 32'h0);
    exp_q.delete();
    res_q.delete();
  endtask

  initial begin
    int o0;
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_awvalid", {31'b0, bus.awvalid}, 32'h0);
    chk("rst_wvalid",  {31'b0, bus.wvalid},  32'h0);
    chk("rst_bready",  {31'b0, bus.bready},  32'h0);
    chk("rst_arvalid", {31'b0, bus.arvalid}, 32'h0);
    chk("rst_rready",  {31'b0, bus.rready},  32'h0);
    chk("rst_addrs",   {16'b0, bus.awaddr, bus.araddr}, 32'h0);
    chk("rst_wdata",   bus.wdata, 32'h0);
    chk("rst_flags",   {28'b0, busy, done, err, res_valid}, 32'h0);
    chk("rst_payload", {4'b0, res_target, res_amp}, 32'h0);
    rst = 1'b0;
    tick();

    // Single target, hit on second poll, amp -5
    res_ready = 1'b1; hit_poll = 2;
    model_sweep(3, 3, 16'h0000);
    run(16'h0003, 16'h0003, 16'h0000, 1'b0, 1);
    chk("single_target_lit", {16'b0, last_t}, 32'h0003);
    chk("single_amp_lit", {20'b0, last_a}, 32'hFFB);
    chk("single_polls_lit", 32'(status_reads), 32'd2);

    // Four-target sweep with wait states and stalling consumer
    wait_en = 1'b1; rdy_toggle = 1'b1; hit_poll = 3;
    model_sweep(16'h0E, 16'h11, 16'h00A5);
    run(16'h000E, 16'h0011, 16'h00A5, 1'b0, 4);
    chk("sweep_last_lit", {16'b0, last_t}, 32'h0011);
    wait_en = 1'b0; rdy_toggle = 1'b0; res_ready = 1'b1;

    // Wrap boundary
    hit_poll = 1;
    model_sweep(16'hFFFF, 16'hFFFF, 16'h1234);
    run(16'hFFFF, 16'hFFFF, 16'h1234, 1'b0, 1);
    chk("wrap_target_lit", {16'b0, last_t}, 32'hFFFF);

    // SN reads zero
    sn_val = 32'h0;
    push_r(8'h00);
    run(16'h0001, 16'h0002, 16'h0, 1'b1, 0);
    sn_val = 32'h5151_0001;

    // BRESP error on the go write
    bresp_on_go = 1'b1;
    push_r(8'h00); push_w(8'h08, 32'h5); push_w(8'h0C, 32'h7); push_w(8'h10, 32'h1);
    run(16'h0005, 16'h0006, 16'h0007, 1'b1, 0);
    bresp_on_go = 1'b0;

    // Poll timeout: status never reaches result state
    hit_poll = 0;
    push_r(8'h00); push_w(8'h08, 32'h9); push_w(8'h0C, 32'h0); push_w(8'h10, 32'h1);
    for (int p = 0; p < 8; p++) push_r(8'h04);
    run(16'h0009, 16'h0009, 16'h0000, 1'b1, 0);
    chk("timeout_polls_lit", 32'(status_reads), 32'd8);
    hit_poll = 2;

    // Reversed range: error, no traffic
    o0 = obs_wr;
    run(16'h0005, 16'h0004, 16'h0000, 1'b1, 0);
    chk("badrange_traffic_lit", 32'(obs_wr - o0), 32'd0);

    // Reset while AWVALID is outstanding, then a clean run
    hold_aw = 1'b1;
    push_r(8'h00);
    init_state = 16'h0; tgt_first = 16'h0007; tgt_last = 16'h0007;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && !bus.awvalid; c++) tick();
    chk("awvalid_reached", {31'b0, bus.awvalid}, 32'h1);
    rst = 1'b1;
    tick();
    chk("midrst_valids", {27'b0, bus.awvalid, bus.wvalid, bus.arvalid, res_valid, busy}, 32'h0);
    chk("midrst_readys", {30'b0, bus.bready, bus.rready}, 32'h0);
    tick();
    rst = 1'b0; hold_aw = 1'b0;
    tick();
    chk("midrst_traffic_left", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    model_sweep(7, 7, 16'h0003);
    run(16'h0007, 16'h0007, 16'h0003, 1'b0, 1);
    chk("post_rst_target_lit", {16'b0, last_t}, 32'h0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
